timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
Avalon-MM master that owns the 16-bit interval-timer slave. It converts single-handshake software/hardware commands (START, STOP, SNAP) into the timer's multi-write register sequences. It services the timer IRQ by clearing the TO status, pulsing a timeout event and counting timeouts. It sits between the requester, a control FSM or bridge, and the timer's s1 port. It is the timer's only master.

Parameters:
IRQ_EN, 1, value programmed into control bit0 (ITO) on START.
CNT_W, 16, width of the saturating timeout counter.
MIN_PERIOD, 2, lower clamp applied to cmd_period before programming.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  0=START, 1=STOP, 2=SNAP, 3=reserved (treated as NOP)
cmd_period  in  32  period for START
cmd_continuous  in  1  continuous mode for START
rsp_valid  out  1  1-cycle pulse: command sequence finished
rsp_snapshot  out  32  counter snapshot; valid with rsp_valid after SNAP, else holds last value
evt_timeout  out  1  1-cycle pulse per serviced timer IRQ
timeout_count  out  CNT_W  saturating count of evt_timeout
busy  out  1  FSM not in IDLE
tmr_address  out  3  timer register index
tmr_chipselect  out  1  timer select
tmr_write_n  out  1  active-low write strobe
tmr_writedata  out  16  write data
tmr_readdata  in  16  timer read data, registered, valid 1 cycle after address
tmr_irq  in  1  timer interrupt (level)

Behaviour:
- Timer map: 0 status (write clears TO; bit1=RUN), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h (a write to 4 captures the counter). Writes are single-cycle with no waitrequest.
- Reset: state=IDLE. cmd_ready=0 during reset. rsp_valid=0, evt_timeout=0, busy=0, rsp_snapshot=0, timeout_count=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
- Bus idle: chipselect=0, write_n=1, address and writedata hold their last value.
- IDLE: cmd_ready = ~tmr_irq. tmr_irq has priority over a simultaneous cmd_valid, so the command is not accepted that cycle.
- IRQ service: IDLE & tmr_irq -> CLR_TO. Write status (addr 0, data 0) for 1 cycle. In the same cycle pulse evt_timeout and increment timeout_count (saturates at all-ones). Then go to IRQ_WAIT for 1 idle cycle so the timer's irq deasserts, then IDLE.
- START (one bus cycle per state):
  - WR_STOP: ctrl=0x0008.
  - WR_PL: period_l.
  - WR_PH: period_h. Periods are written before START because a period write stops the timer.
  - WR_CTRL: ctrl = {0,1'b1(START),cmd_continuous,IRQ_EN}.
  - DONE: rsp_valid. Total is 5 cycles from acceptance to rsp_valid.
  - Period is clamped: if cmd_period < MIN_PERIOD, program MIN_PERIOD.
- STOP: WR_STOP(ctrl=0x0008) -> DONE. Issuing STOP while the timer is already stopped is legal and the same sequence runs.
- SNAP:
  - WR_SNAP: addr 4, write.
  - RD_L: addr 4, read (chipselect=1, write_n=1).
  - RD_H: addr 5, read; capture readdata into snapshot[15:0].
  - RD_CAP: capture readdata into snapshot[31:16].
  - DONE: rsp_valid with rsp_snapshot updated.
- cmd_op=3: DONE directly with rsp_valid; the bus is not touched.
- Command fields are registered at acceptance. Input changes during a sequence have no effect.
- A tmr_irq that rises mid-sequence is serviced on the next return to IDLE. The sequence is never interrupted. If the irq appeared during START, the stale TO is cleared after that START completes.
- Reset mid-sequence: the FSM aborts to IDLE immediately and the timer may be left half-programmed. Every START begins with a STOP write, so the next START reprograms the timer fully.
- busy=1 in every state except IDLE. rsp_valid and evt_timeout are never asserted in the same cycle.

Decomposition:
- Package timer_seq_pkg: op codes (OP_START/OP_STOP/OP_SNAP/OP_NOP), timer register indices, control bit positions, state enum.
- One sub-module, timer_seq_bus_drv: registered Avalon write/read strobe generator, taking a request of {addr, data, rd/wr} per cycle.
- FSM and counters stay in the top module.

Test Plan:
1. START period=0x0001_86A0, cont=1 -> writes ctrl=0x0008, pl=0x86A0, ph=0x0001, ctrl=0x0007 on 4 consecutive cycles; rsp_valid on cycle 5.
2. START period=0 -> period_l written 0x0002, period_h 0x0000 (MIN_PERIOD clamp).
3. SNAP with timer model counter=0x0003_1234 -> write addr4, read addr4, read addr5; rsp_snapshot=0x0003_1234 with rsp_valid.
4. tmr_irq and cmd_valid(STOP) in the same IDLE cycle -> cmd_ready=0, status write addr0, evt_timeout pulse, timeout_count=1; STOP accepted afterwards.
5. 70000 serviced IRQs with CNT_W=16 -> timeout_count saturates at 0xFFFF.
6. Reset asserted during WR_PH -> next cycle all outputs at reset values; following START begins with ctrl=0x0008.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared definitions for the interval-timer sequencer: command codes, timer
// register map, control-register bit positions and the sequencer state set.
package timer_seq_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_SNAP  = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_TO,
        ST_IRQ_WAIT,
        ST_WR_STOP,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WR_SNAP,
        ST_RD_L,
        ST_RD_H,
        ST_RD_CAP,
        ST_DONE
    } state_t;

    function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w = '0;
        w[CTRL_ITO]   = ito;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_seq_bus_drv.sv
// Registered Avalon-MM strobe generator for the timer s1 port. One request per
// cycle in, the matching bus cycle out on the next clock; address/data hold when idle.
module timer_seq_bus_drv (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic        req_wr,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_data,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata
);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_address    <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
        end else begin
            tmr_chipselect <= req_en;
            tmr_write_n    <= ~(req_en & req_wr);
            if (req_en) begin
                tmr_address <= req_addr;
            end
            // Reads leave the last write data on the bus untouched.
            if (req_en && req_wr) begin
                tmr_writedata <= req_data;
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Sole Avalon-MM master of the 16-bit interval timer: expands START/STOP/SNAP
// commands into register sequences and services the timeout interrupt.
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int IRQ_EN     = 1,
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_continuous,
    output logic             rsp_valid,
    output logic [31:0]      rsp_snapshot,
    output logic             evt_timeout,
    output logic [CNT_W-1:0] timeout_count,
    output logic             busy,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq
);

    localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
    localparam logic        ITO_BIT = (IRQ_EN != 0);

    state_t      state;
    state_t      next_state;
    logic [1:0]  op_q;
    logic [31:0] period_q;
    logic        cont_q;
    logic [15:0] snap_lo;
    logic        accept;

    logic        req_en;
    logic        req_wr;
    logic [2:0]  req_addr;
    logic [15:0] req_data;

    // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready.
    // cmd_ready is only offered in IDLE with no pending timer IRQ, and never in reset;
    // exactly one rsp_valid pulse follows every accepted command.
    assign cmd_ready = (state == ST_IDLE) && !tmr_irq && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (tmr_irq) begin
                    next_state = ST_CLR_TO;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OP_START: next_state = ST_WR_STOP;
                        OP_STOP:  next_state = ST_WR_STOP;
                        OP_SNAP:  next_state = ST_WR_SNAP;
                        default:  next_state = ST_DONE;
                    endcase
                end
            end
            ST_CLR_TO:   next_state = ST_IRQ_WAIT;
            ST_IRQ_WAIT: next_state = ST_IDLE;
            ST_WR_STOP:  next_state = (op_q == OP_START) ? ST_WR_PL : ST_DONE;
            ST_WR_PL:    next_state = ST_WR_PH;
            ST_WR_PH:    next_state = ST_WR_CTRL;
            ST_WR_CTRL:  next_state = ST_DONE;
            ST_WR_SNAP:  next_state = ST_RD_L;
            ST_RD_L:     next_state = ST_RD_H;
            ST_RD_H:     next_state = ST_RD_CAP;
            ST_RD_CAP:   next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // The bus request is keyed on the state being entered so that the registered
    // strobe lands in the same cycle as the state it belongs to.
    always_comb begin
        req_en   = 1'b0;
        req_wr   = 1'b0;
        req_addr = REG_STATUS;
        req_data = 16'h0000;
        case (next_state)
            ST_CLR_TO: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = REG_STATUS;
            end
            ST_WR_STOP: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = REG_CONTROL;
                req_data = ctrl_word(1'b0, 1'b1, 1'b0, 1'b0);
            end
            ST_WR_PL: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = REG_PERIOD_L;
                req_data = period_q[15:0];
            end
            ST_WR_PH: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = REG_PERIOD_H;
                req_data = period_q[31:16];
            end
            ST_WR_CTRL: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = REG_CONTROL;
                req_data = ctrl_word(1'b1, 1'b0, cont_q, ITO_BIT);
            end
            ST_WR_SNAP: begin
                req_en   = 1'b1;
                req_wr   = 1'b1;
                req_addr = REG_SNAP_L;
            end
            ST_RD_L: begin
                req_en   = 1'b1;
                req_addr = REG_SNAP_L;
            end
            ST_RD_H: begin
                req_en   = 1'b1;
                req_addr = REG_SNAP_H;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= OP_NOP;
            period_q      <= '0;
            cont_q        <= 1'b0;
            snap_lo       <= '0;
            rsp_snapshot  <= '0;
            rsp_valid     <= 1'b0;
            evt_timeout   <= 1'b0;
            timeout_count <= '0;
        end else begin
            state       <= next_state;
            rsp_valid   <= (next_state == ST_DONE);
            evt_timeout <= (next_state == ST_CLR_TO);
            if (next_state == ST_CLR_TO && timeout_count != {CNT_W{1'b1}}) begin
                timeout_count <= timeout_count + CNT_W'(1);
            end
            if (accept) begin
                op_q     <= cmd_op;
                cont_q   <= cmd_continuous;
                period_q <= (cmd_period < MIN_P) ? MIN_P : cmd_period;
            end
            // readdata trails the address by one cycle: low half arrives in RD_H.
            if (state == ST_RD_H) begin
                snap_lo <= tmr_readdata;
            end
            if (state == ST_RD_CAP) begin
                rsp_snapshot <= {tmr_readdata, snap_lo};
            end
        end
    end

    timer_seq_bus_drv u_bus_drv (
        .clk            (clk),
        .reset          (reset),
        .req_en         (req_en),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata)
    );

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed + randomized bench for timer_sequencer with a behavioural timer slave.
module tb_timer_sequencer;
    import timer_seq_pkg::*;

    localparam int IRQ_EN     = 1;
    localparam int CNT_W      = 4;
    localparam int MIN_PERIOD = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [31:0]      cmd_period = 32'd0;
    logic             cmd_continuous = 1'b0;
    logic             rsp_valid;
    logic [31:0]      rsp_snapshot;
    logic             evt_timeout;
    logic [CNT_W-1:0] timeout_count;
    logic             busy;
    logic [2:0]       tmr_address;
    logic             tmr_chipselect;
    logic             tmr_write_n;
    logic [15:0]      tmr_writedata;
    logic [15:0]      tmr_readdata = 16'h0;
    logic             tmr_irq = 1'b0;

    logic             irq_raise = 1'b0;
    logic [31:0]      tm_counter = 32'h0;
    logic [31:0]      tm_snap = 32'h0;

    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] exp_count = '0;
    logic [31:0]      exp_snap = 32'h0;

    typedef struct packed {
        logic        idle;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        dchk;
    } bus_exp_t;

    bus_exp_t exp_q[$];

    always #5 clk = ~clk;

    timer_sequencer #(
        .IRQ_EN     (IRQ_EN),
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .rsp_valid      (rsp_valid),
        .rsp_snapshot   (rsp_snapshot),
        .evt_timeout    (evt_timeout),
        .timeout_count  (timeout_count),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
    );

    // Timer slave: status write clears the interrupt, write to snap_l latches the counter.
    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) tmr_irq <= 1'b0;
        else if (irq_raise) tmr_irq <= 1'b1;
        if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) tm_snap <= tm_counter;
        if (tmr_chipselect && tmr_write_n)
            tmr_readdata <= (tmr_address == 3'd4) ? tm_snap[15:0] :
                            (tmr_address == 3'd5) ? tm_snap[31:16] : 16'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bus_exp_t mk(input logic idle, input logic wr, input logic [2:0] addr,
                                    input logic [15:0] data, input logic dchk);
        bus_exp_t e;
        e.idle = idle; e.wr = wr; e.addr = addr; e.data = data; e.dchk = dchk;
        return e;
    endfunction

    // Expected bus cycles following acceptance, straight from the timer programming rules.
    task automatic build_exp(input logic [1:0] op, input logic [31:0] per, input logic cont);
        logic [31:0] eff;
        logic [15:0] ctrl;
        exp_q.delete();
        eff  = (per < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : per;
        ctrl = 16'h0004 | (cont ? 16'h0002 : 16'h0000) | ((IRQ_EN != 0) ? 16'h0001 : 16'h0000);
        case (op)
            2'd0: begin
                exp_q.push_back(mk(1'b0, 1'b1, 3'd1, 16'h0008, 1'b1));
                exp_q.push_back(mk(1'b0, 1'b1, 3'd2, eff[15:0], 1'b1));
                exp_q.push_back(mk(1'b0, 1'b1, 3'd3, eff[31:16], 1'b1));
                exp_q.push_back(mk(1'b0, 1'b1, 3'd1, ctrl, 1'b1));
            end
            2'd1: exp_q.push_back(mk(1'b0, 1'b1, 3'd1, 16'h0008, 1'b1));
            2'd2: begin
                exp_q.push_back(mk(1'b0, 1'b1, 3'd4, 16'h0, 1'b0));
                exp_q.push_back(mk(1'b0, 1'b0, 3'd4, 16'h0, 1'b0));
                exp_q.push_back(mk(1'b0, 1'b0, 3'd5, 16'h0, 1'b0));
                exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b0));
            end
            default: ;
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                           input logic irq_mid, input int abort_at);
        int guard;
        bus_exp_t e;
        build_exp(op, per, cont);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_continuous = cont;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 16) begin
            @(negedge clk); #1; guard++;
        end
        chk("accept_wait", {31'b0, cmd_ready}, 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        irq_raise = irq_mid;
        for (int i = 1; i <= exp_q.size() + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cmd_valid = 1'b0;
                cmd_op = 2'($urandom_range(0, 3));
                cmd_period = $urandom;
                cmd_continuous = 1'($urandom_range(0, 1));
                irq_raise = 1'b0;
            end
            chk("busy_in_seq", {31'b0, busy}, 32'd1);
            chk("evt_in_seq", {31'b0, evt_timeout}, 32'd0);
            if (i <= exp_q.size()) begin
                e = exp_q[i-1];
                chk("rsp_early", {31'b0, rsp_valid}, 32'd0);
                chk("bus_cs", {31'b0, tmr_chipselect}, {31'b0, !e.idle});
                chk("bus_write_n", {31'b0, tmr_write_n}, {31'b0, !e.wr});
                if (!e.idle) chk("bus_addr", {29'b0, tmr_address}, {29'b0, e.addr});
                if (e.dchk) chk("bus_wdata", {16'b0, tmr_writedata}, {16'b0, e.data});
                if (i == abort_at) begin
                    reset = 1'b1;
                    return;
                end
            end else begin
                chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
                chk("bus_idle_done", {31'b0, tmr_chipselect}, 32'd0);
                if (op == 2'd2) exp_snap = tm_counter;
                chk("rsp_snapshot", rsp_snapshot, exp_snap);
            end
        end
    endtask

    // Entered at a negedge in IDLE while tmr_irq is high.
    task automatic check_service();
        if (exp_count != {CNT_W{1'b1}}) exp_count = exp_count + 1'b1;
        @(negedge clk);
        chk("svc_cs", {31'b0, tmr_chipselect}, 32'd1);
        chk("svc_write_n", {31'b0, tmr_write_n}, 32'd0);
        chk("svc_addr", {29'b0, tmr_address}, 32'd0);
        chk("svc_wdata", {16'b0, tmr_writedata}, 32'd0);
        chk("svc_evt", {31'b0, evt_timeout}, 32'd1);
        chk("svc_count", 32'(timeout_count), 32'(exp_count));
        chk("svc_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("svc_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("wait_evt", {31'b0, evt_timeout}, 32'd0);
        chk("wait_cs", {31'b0, tmr_chipselect}, 32'd0);
        chk("wait_busy", {31'b0, busy}, 32'd1);
        chk("wait_count", 32'(timeout_count), 32'(exp_count));
    endtask

    task automatic chk_reset_values();
        chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("rst_evt", {31'b0, evt_timeout}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_snapshot", rsp_snapshot, 32'd0);
        chk("rst_count", 32'(timeout_count), 32'd0);
        chk("rst_cs", {31'b0, tmr_chipselect}, 32'd0);
        chk("rst_write_n", {31'b0, tmr_write_n}, 32'd1);
        chk("rst_addr", {29'b0, tmr_address}, 32'd0);
        chk("rst_wdata", {16'b0, tmr_writedata}, 32'd0);
    endtask

    initial begin
        logic       irq_mid;
        logic [1:0] op;
        logic [31:0] per;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_values();
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, cmd_ready}, 32'd1);

        run_cmd(2'd0, 32'h0001_86A0, 1'b1, 1'b0, 0);
        run_cmd(2'd0, 32'h0000_0000, 1'b0, 1'b0, 0);
        run_cmd(2'd0, 32'h0000_0001, 1'b1, 1'b0, 0);
        run_cmd(2'd0, 32'h0000_0002, 1'b0, 1'b0, 0);
        tm_counter = 32'h0003_1234;
        run_cmd(2'd2, 32'h0, 1'b0, 1'b0, 0);
        run_cmd(2'd1, 32'h0, 1'b0, 1'b0, 0);
        run_cmd(2'd1, 32'h0, 1'b0, 1'b0, 0);
        run_cmd(2'd3, 32'h0, 1'b0, 1'b0, 0);

        // IRQ and STOP offered in the same IDLE cycle: IRQ wins.
        @(negedge clk); irq_raise = 1'b1;
        @(negedge clk); irq_raise = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd1;
        #1;
        chk("irq_prio_ready", {31'b0, cmd_ready}, 32'd0);
        check_service();
        run_cmd(2'd1, 32'h0, 1'b0, 1'b0, 0);

        // IRQ arriving mid-START is serviced only after the sequence completes.
        run_cmd(2'd0, 32'h0000_1000, 1'b1, 1'b1, 0);
        @(negedge clk);
        chk("stale_idle_busy", {31'b0, busy}, 32'd0);
        check_service();

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            per = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            tm_counter = $urandom;
            irq_mid = ($urandom_range(0, 3) == 0);
            run_cmd(op, per, 1'($urandom_range(0, 1)), irq_mid, 0);
            if (irq_mid) begin
                @(negedge clk);
                chk("rand_idle_busy", {31'b0, busy}, 32'd0);
                chk("rand_irq_ready", {31'b0, cmd_ready}, 32'd0);
                check_service();
            end
        end

        // Drive the timeout counter into saturation.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); irq_raise = 1'b1;
            @(negedge clk); irq_raise = 1'b0;
            check_service();
        end
        chk("count_saturated", 32'(timeout_count), 32'((1 << CNT_W) - 1));

        // Reset while the period high half is being written.
        run_cmd(2'd0, 32'h0005_0005, 1'b1, 1'b0, 3);
        @(negedge clk);
        chk_reset_values();
        reset = 1'b0;
        exp_count = '0;
        exp_snap = 32'h0;
        run_cmd(2'd0, 32'h0000_0100, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
